// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one command at a time, enables the selected
// execution unit, waits (bounded) for its flag and returns the captured result.
module alu_op_sequencer #(
    parameter int unsigned in_width  = 8,
    parameter int unsigned out_width = 16,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [in_width-1:0]  cmd_A,
    input  logic [in_width-1:0]  cmd_B,
    input  logic [3:0]           cmd_FUN,
    output logic [in_width-1:0]  A,
    output logic [in_width-1:0]  B,
    output logic [1:0]           ALU_FUN,
    output logic                 Arith_Enable,
    output logic                 Logic_Enable,
    output logic                 CMP_Enable,
    output logic                 SHIFT_Enable,
    input  logic [out_width-1:0] Arith_OUT,
    input  logic [out_width-1:0] Logic_OUT,
    input  logic [out_width-1:0] CMP_OUT,
    input  logic [out_width-1:0] SHIFT_OUT,
    input  logic                 Arith_Flag,
    input  logic                 Logic_Flag,
    input  logic                 CMP_Flag,
    input  logic                 SHIFT_Flag,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [out_width-1:0] res_data,
    output logic [1:0]           res_unit,
    output logic                 res_err
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [in_width-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]           fun_q, fun_d;
    logic [1:0]           sel_q, sel_d;
    // Enable bit order: 0 arith, 1 logic, 2 cmp, 3 shift (matches unit select code).
    logic [3:0]           en_q, en_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 res_valid_q, res_valid_d;
    logic [out_width-1:0] res_data_q, res_data_d;
    logic [1:0]           res_unit_q, res_unit_d;
    logic                 res_err_q, res_err_d;

    logic                 sel_flag;
    logic [out_width-1:0] sel_out;

    // Only the unit chosen by the latched select is observed; other flags are ignored.
    always_comb begin
        sel_flag = 1'b0;
        sel_out  = '0;
        case (sel_q)
            2'd0: begin sel_flag = Arith_Flag; sel_out = Arith_OUT; end
            2'd1: begin sel_flag = Logic_Flag; sel_out = Logic_OUT; end
            2'd2: begin sel_flag = CMP_Flag;   sel_out = CMP_OUT;   end
            default: begin sel_flag = SHIFT_Flag; sel_out = SHIFT_OUT; end
        endcase
    end

    // Next-state logic: every output is a register, so all decisions land here.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        sel_d       = sel_q;
        en_d        = en_q;
        cmd_ready_d = cmd_ready_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_unit_d  = res_unit_q;
        res_err_d   = res_err_q;
        case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                en_d        = '0;
                // cmd_ready_q gates acceptance so the first cycle after reset never accepts.
                if (cmd_valid && cmd_ready_q) begin
                    a_d         = cmd_A;
                    b_d         = cmd_B;
                    fun_d       = cmd_FUN[1:0];
                    sel_d       = cmd_FUN[3:2];
                    en_d        = 4'b0001 << cmd_FUN[3:2];
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                cmd_ready_d = 1'b0;
                if (sel_flag) begin
                    res_data_d  = sel_out;
                    res_unit_d  = sel_q;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    en_d        = '0;
                    state_d     = StResp;
                end else if (cnt_q == CntLast) begin
                    res_data_d  = '0;
                    res_unit_d  = sel_q;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    en_d        = '0;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                cmd_ready_d = 1'b0;
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                en_d        = '0;
                cmd_ready_d = 1'b0;
                res_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears everything, aborting any operation.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            sel_q       <= '0;
            en_q        <= '0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_unit_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_unit_q  <= res_unit_d;
            res_err_q   <= res_err_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign A            = a_q;
    assign B            = b_q;
    assign ALU_FUN      = fun_q;
    assign Arith_Enable = en_q[0];
    assign Logic_Enable = en_q[1];
    assign CMP_Enable   = en_q[2];
    assign SHIFT_Enable = en_q[3];
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_unit     = res_unit_q;
    assign res_err      = res_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with simple 1-cycle-latency unit models.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_A = '0, cmd_B = '0;
    logic [3:0]  cmd_FUN = '0;
    logic [7:0]  A, B;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
    logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [1:0]  res_unit;
    logic        res_err;

    logic [3:0]  flag_allow = 4'hF;
    logic [3:0]  stray = 4'h0;
    logic [3:0]  flag_q = 4'h0;
    logic [15:0] out_q [4];

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.in_width(8), .out_width(16), .TIMEOUT(4)) dut (
        .clk(clk), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_FUN(cmd_FUN),
        .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag),
        .SHIFT_Flag(SHIFT_Flag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_unit(res_unit), .res_err(res_err)
    );

    function automatic logic [15:0] unit_f(input int u, input logic [1:0] f,
                                          input logic [7:0] a, input logic [7:0] b);
        logic [15:0] x, y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (u)
            0: case (f) 2'd0: return x + y; 2'd1: return x - y; 2'd2: return x * y;
                        default: return x; endcase
            1: case (f) 2'd0: return x & y; 2'd1: return x | y; 2'd2: return ~(x & y);
                        default: return ~(x | y); endcase
            2: case (f) 2'd0: return {15'd0, a == b}; 2'd1: return {15'd0, a > b};
                        2'd2: return {15'd0, a < b}; default: return {15'd0, a != b}; endcase
            default: case (f) 2'd0: return x >> 1; 2'd1: return x << 1; 2'd2: return y >> 1;
                        default: return y << 1; endcase
        endcase
    endfunction

    // Unit models: flag and result register one edge after the enable.
    always_ff @(posedge clk) begin
        flag_q <= {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable} & flag_allow;
        for (int u = 0; u < 4; u++) out_q[u] <= unit_f(u, ALU_FUN, A, B);
    end

    assign Arith_Flag = flag_q[0] | stray[0];
    assign Logic_Flag = flag_q[1] | stray[1];
    assign CMP_Flag   = flag_q[2] | stray[2];
    assign SHIFT_Flag = flag_q[3] | stray[3];
    assign Arith_OUT  = out_q[0];
    assign Logic_OUT  = out_q[1];
    assign CMP_OUT    = out_q[2];
    assign SHIFT_OUT  = out_q[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command once cmd_ready is seen; returns 1 ns after the accepting edge.
    task automatic issue(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            tests++; failed++;
            $display("FAIL issue_wait cmd_ready got=%b exp=1", cmd_ready);
        end
        cmd_FUN = fun; cmd_A = a; cmd_B = b; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({cmd_ready, Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable, res_valid, res_err}
            !== 7'b0 || res_data !== 16'h0 || A !== 8'h0) begin
            failed++;
            $display("FAIL reset_outputs cmd_ready=%b res_valid=%b res_data=%h exp all 0",
                     cmd_ready, res_valid, res_data);
        end
        @(negedge clk);
        RST = 1'b1;
        tick();
        tests++;
        if (cmd_ready !== 1'b1) begin
            failed++; $display("FAIL reset_release cmd_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_logic_and();
        issue(4'b0100, 8'd15, 8'd30);
        tests++;
        if (Logic_Enable !== 1'b1 || A !== 8'd15 || B !== 8'd30 || ALU_FUN !== 2'b00
            || cmd_ready !== 1'b0) begin
            failed++;
            $display("FAIL and_accept en=%b A=%0d B=%0d fun=%b exp en=1 A=15 B=30 fun=00",
                     Logic_Enable, A, B, ALU_FUN);
        end
        tick();
        tests++;
        if (Logic_Enable !== 1'b1 || res_valid !== 1'b0) begin
            failed++;
            $display("FAIL and_wait en=%b res_valid=%b exp en=1 valid=0", Logic_Enable, res_valid);
        end
        tick();
        tests++;
        if (res_valid !== 1'b1 || Logic_Enable !== 1'b0 || res_data !== 16'd14
            || res_unit !== 2'b01 || res_err !== 1'b0) begin
            failed++;
            $display("FAIL and_result valid=%b en=%b data=%h unit=%b err=%b exp 1 0 000e 01 0",
                     res_valid, Logic_Enable, res_data, res_unit, res_err);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failed++;
            $display("FAIL and_handshake valid=%b cmd_ready=%b exp 0 1", res_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b1;
        issue(4'b0101, 8'd50, 8'd15);
        // Second command offered while the first is in flight.
        cmd_FUN = 4'b0110; cmd_A = 8'd50; cmd_B = 8'd15; cmd_valid = 1'b1;
        tick();
        tests++;
        if (ALU_FUN !== 2'b01 || Logic_Enable !== 1'b1 || cmd_ready !== 1'b0) begin
            failed++;
            $display("FAIL b2b_hold fun=%b en=%b cmd_ready=%b exp 01 1 0",
                     ALU_FUN, Logic_Enable, cmd_ready);
        end
        tick();
        tests++;
        if (res_valid !== 1'b1 || res_data !== 16'd63 || cmd_ready !== 1'b0) begin
            failed++;
            $display("FAIL b2b_first valid=%b data=%h cmd_ready=%b exp 1 003f 0",
                     res_valid, res_data, cmd_ready);
        end
        tick();
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || Logic_Enable !== 1'b0) begin
            failed++;
            $display("FAIL b2b_gap valid=%b cmd_ready=%b en=%b exp 0 1 0",
                     res_valid, cmd_ready, Logic_Enable);
        end
        tick();
        cmd_valid = 1'b0;
        tests++;
        if (Logic_Enable !== 1'b1 || ALU_FUN !== 2'b10 || cmd_ready !== 1'b0) begin
            failed++;
            $display("FAIL b2b_accept2 en=%b fun=%b cmd_ready=%b exp 1 10 0",
                     Logic_Enable, ALU_FUN, cmd_ready);
        end
        tick();
        tick();
        tests++;
        if (res_valid !== 1'b1 || res_data !== 16'hFFFD || res_unit !== 2'b01) begin
            failed++;
            $display("FAIL b2b_second valid=%b data=%h unit=%b exp 1 fffd 01",
                     res_valid, res_data, res_unit);
        end
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_res_stall();
        issue(4'b0100, 8'd15, 8'd30);
        tick();
        tick();
        cmd_FUN = 4'b0000; cmd_A = 8'd1; cmd_B = 8'd2; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (res_valid !== 1'b1 || res_data !== 16'd14 || res_unit !== 2'b01
                || cmd_ready !== 1'b0 || Arith_Enable !== 1'b0) begin
                failed++;
                $display("FAIL stall_hold%0d valid=%b data=%h unit=%b cmd_ready=%b aen=%b",
                         i, res_valid, res_data, res_unit, cmd_ready, Arith_Enable);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || res_data !== 16'd14
            || Arith_Enable !== 1'b0) begin
            failed++;
            $display("FAIL stall_release valid=%b cmd_ready=%b data=%h aen=%b exp 0 1 000e 0",
                     res_valid, cmd_ready, res_data, Arith_Enable);
        end
        tick();
        cmd_valid = 1'b0;
        tests++;
        if (Arith_Enable !== 1'b1 || A !== 8'd1 || B !== 8'd2) begin
            failed++;
            $display("FAIL stall_pending aen=%b A=%0d B=%0d exp 1 1 2", Arith_Enable, A, B);
        end
        tick();
        tick();
        tests++;
        if (res_valid !== 1'b1 || res_data !== 16'd3 || res_unit !== 2'b00) begin
            failed++;
            $display("FAIL stall_add valid=%b data=%h unit=%b exp 1 0003 00",
                     res_valid, res_data, res_unit);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_timeout();
        flag_allow[2] = 1'b0;
        issue(4'b1000, 8'd5, 8'd5);
        stray[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 1) stray[1] = 1'b0;
            tests++;
            if (res_valid !== 1'b0 || CMP_Enable !== 1'b1) begin
                failed++;
                $display("FAIL timeout_wait%0d valid=%b cen=%b exp 0 1", i, res_valid, CMP_Enable);
            end
        end
        tick();
        tests++;
        if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 16'h0 || CMP_Enable !== 1'b0) begin
            failed++;
            $display("FAIL timeout_err valid=%b err=%b data=%h cen=%b exp 1 1 0000 0",
                     res_valid, res_err, res_data, CMP_Enable);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || res_err !== 1'b0) begin
            failed++;
            $display("FAIL timeout_clear valid=%b err=%b exp 0 0", res_valid, res_err);
        end
        flag_allow[2] = 1'b1;
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        flag_allow[3] = 1'b0;
        issue(4'b1100, 8'h81, 8'h02);
        tick();
        tests++;
        if (SHIFT_Enable !== 1'b1) begin
            failed++; $display("FAIL abort_pre sen=%b exp 1", SHIFT_Enable);
        end
        #2 RST = 1'b0;
        #1;
        tests++;
        if ({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable} !== 4'b0 || cmd_ready !== 1'b0
            || A !== 8'h0 || ALU_FUN !== 2'b00 || res_data !== 16'h0) begin
            failed++;
            $display("FAIL abort_async sen=%b cmd_ready=%b A=%h fun=%b data=%h exp all 0",
                     SHIFT_Enable, cmd_ready, A, ALU_FUN, res_data);
        end
        tick();
        RST = 1'b1;
        flag_allow[3] = 1'b1;
        tick();
        tests++;
        if (cmd_ready !== 1'b1) begin
            failed++; $display("FAIL abort_ready cmd_ready=%b exp 1", cmd_ready);
        end
        for (int i = 0; i < 6; i++) begin
            if (res_valid !== 1'b0 || SHIFT_Enable !== 1'b0) seen++;
            tick();
        end
        tests++;
        if (seen != 0) begin
            failed++; $display("FAIL abort_no_result cycles_with_activity=%0d exp 0", seen);
        end
    endtask

    task automatic test_decode();
        logic [3:0]  funs [4] = '{4'b0000, 4'b0111, 4'b1010, 4'b1101};
        logic [15:0] exp_d [4] = '{16'h0046, 16'hFFC9, 16'h0001, 16'h0024};
        logic [3:0]  en;
        for (int i = 0; i < 4; i++) begin
            issue(funs[i], 8'h12, 8'h34);
            en = {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
            tests++;
            if (en !== (4'b0001 << i) || ALU_FUN !== funs[i][1:0]) begin
                failed++;
                $display("FAIL decode_en%0d en=%b fun=%b exp en=%b fun=%b",
                         i, en, ALU_FUN, 4'b0001 << i, funs[i][1:0]);
            end
            tick();
            tick();
            tests++;
            if (res_valid !== 1'b1 || res_data !== exp_d[i] || res_unit !== 2'(i)) begin
                failed++;
                $display("FAIL decode_res%0d valid=%b data=%h unit=%b exp 1 %h %0d",
                         i, res_valid, res_data, res_unit, exp_d[i], i);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_logic_and();
        test_back_to_back();
        test_res_stall();
        test_timeout();
        test_reset_abort();
        test_decode();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator for the hierarchical ALU's execution units (arithmetic, logic, compare, shift).
- Accepts operation commands over a valid/ready handshake and decodes the 4-bit function code into one unit enable plus a 2-bit unit function.
- Holds operands and enable until the selected unit raises its flag, then captures the result.
- Returns the result over a second valid/ready handshake, with a timeout error path for a unit that never responds.

Parameters:
- in_width, 8, operand width
- out_width, 16, result width
- TIMEOUT, 8, max wait cycles for a unit flag before error (≥2)

Ports:
- clk  input  1  clock, rising edge
- RST  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_A  input  in_width  operand A
- cmd_B  input  in_width  operand B
- cmd_FUN  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit function
- A  output  in_width  operand A to units
- B  output  in_width  operand B to units
- ALU_FUN  output  2  unit function
- Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable  output  1 each  unit enables, at most one high
- Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT  input  out_width each  unit results
- Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  input  1 each  unit result-valid flags
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  out_width  captured result
- res_unit  output  2  unit that produced res_data (cmd_FUN[3:2])
- res_err  output  1  timeout occurred, res_data=0

Behaviour:
- All outputs are registered. RST low forces the following immediately: state IDLE, every output 0 (cmd_ready 0 while RST low), wait counter 0.
- IDLE:
  - cmd_ready=1 and all enables 0.
  - On cmd_valid&cmd_ready at an edge: latch cmd_A/cmd_B/cmd_FUN onto A/B/ALU_FUN and the saved select; raise the decoded enable at that same edge; clear the counter; go to WAIT.
- WAIT:
  - cmd_ready=0. Enable, A, B and ALU_FUN are held stable.
  - Each edge samples only the selected unit's flag; flags of other units are ignored.
  - Selected flag=1: capture the selected unit's result into res_data, set res_unit, res_err=0, res_valid=1, drop the enable, go to RESP.
  - Else, counter reaches TIMEOUT-1: res_data=0, res_err=1, res_valid=1, drop the enable, go to RESP.
  - Else: increment the counter.
- Latency: for a unit that registers its result one edge after its enable, res_valid rises 2 edges after command acceptance.
- RESP:
  - res_valid, res_data, res_unit and res_err are held stable; cmd_ready=0.
  - On res_valid&res_ready: clear res_valid and res_err, go to IDLE with cmd_ready=1 next cycle.
  - No back-to-back overlap: one command is in flight at a time.
  - res_data keeps its last value after the handshake; only res_valid qualifies it.
- cmd_valid asserted during WAIT or RESP is ignored and not accepted; the command must be held until cmd_ready.
- RST asserted mid-WAIT or mid-RESP: the operation is abandoned, the enable drops asynchronously, and no result is produced after release.
- Width rules: res_data is taken verbatim (out_width) from the unit; no sign or zero manipulation.

Test Plan:
- cmd_FUN=0100 (logic AND), A=15, B=30, unit modeled with 1-cycle latency -> Logic_Enable high for exactly 2 cycles; res_valid 2 edges after accept; res_data=14, res_unit=01, res_err=0.
- cmd_FUN=0101 (OR), A=50, B=15; then cmd_FUN=0110 (NAND), A=50, B=15 back-to-back with res_ready=1 -> res_data=63, then res_data=0xFFFD; second cmd_ready rises only after the first result handshake.
- res_ready held low for 3 cycles after res_valid -> res_data/res_unit stable, cmd_ready=0, a pending cmd_valid is not accepted until the handshake completes.
- TIMEOUT=4, cmd_FUN=1000 (cmp), CMP_Flag tied 0, Logic_Flag pulsed during the wait -> after 4 wait edges res_valid=1, res_err=1, res_data=0; the stray Logic_Flag is ignored.
- RST driven low for 1 cycle during WAIT of a shift command -> all enables and outputs 0 immediately; after release cmd_ready=1 next edge and no res_valid is ever produced for the aborted command.
- Decode sweep cmd_FUN[3:2]=00..11 -> exactly one matching enable high per command; ALU_FUN equals cmd_FUN[1:0].
